// File: rtl/axi_slave_write_fifo_if.sv
// AW/W/B channel bundle between the interconnect (master) and the write request queue (slave).
interface axi_slave_write_fifo_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 6
) ();
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [ID_W-1:0]   AWID;
    logic [2:0]        AWPROT;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              WVALID;
    logic              WLAST;
    logic              WREADY;
    logic [ADDR_W-1:0] WADDR_CUR;
    logic [2:0]        WPROT_CUR;
    logic              W_BEAT_EN;
    logic              BVALID;
    logic              BREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;

    modport slave (
        input  AWVALID, AWADDR, AWID, AWPROT, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WLAST, BREADY,
        output AWREADY, WREADY, WADDR_CUR, WPROT_CUR, W_BEAT_EN,
        output BVALID, BID, BRESP
    );

    modport master (
        output AWVALID, AWADDR, AWID, AWPROT, AWLEN, AWSIZE, AWBURST,
        output WVALID, WLAST, BREADY,
        input  AWREADY, WREADY, WADDR_CUR, WPROT_CUR, W_BEAT_EN,
        input  BVALID, BID, BRESP
    );
endinterface

// File: rtl/axi_slave_write_fifo.sv
// In-order AXI write request queue: buffers AW, sequences W beat addresses, returns B in order.
// Optional WLAST_CHECK_EN: end bursts on WLAST or beat count, flag disagreement as SLVERR.
module axi_slave_write_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ID_W       = 6
) (
    input logic                   clk,
    input logic                   reset,
    axi_slave_write_fifo_if.slave bus
);
    localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    logic [ADDR_W-1:0] ent_addr  [ENTRIES];
    logic [ID_W-1:0]   ent_id    [ENTRIES];
    logic [2:0]        ent_prot  [ENTRIES];
    logic [7:0]        ent_len   [ENTRIES];
    logic [2:0]        ent_size  [ENTRIES];
    logic [1:0]        ent_burst [ENTRIES];

    ptr_t       wr_ptr, dat_ptr, rsp_ptr;
    cnt_t       occ, rsp_cnt;
    logic [7:0] beat_cnt;

    logic push, beat, burst_end, b_hs, burst_active, bvalid;
    logic [ADDR_W-1:0] base, offs, mask, sum, cur;

    assign burst_active  = (occ - rsp_cnt) != '0;
    assign bvalid        = rsp_cnt != '0;
    assign bus.AWREADY   = occ != cnt_t'(ENTRIES);
    assign push          = bus.AWVALID & bus.AWREADY;
    assign bus.WREADY    = burst_active;
    assign beat          = bus.WVALID & burst_active;
    assign bus.W_BEAT_EN = beat;
    assign b_hs          = bvalid & bus.BREADY;
    assign bus.BVALID    = bvalid;
    assign bus.BID       = bvalid ? ent_id[rsp_ptr] : '0;
    assign bus.WPROT_CUR = burst_active ? ent_prot[dat_ptr] : '0;
    assign bus.WADDR_CUR = cur;

`ifdef WLAST_CHECK_EN
    logic ent_err [ENTRIES];
    logic len_hit;

    assign len_hit   = beat_cnt == ent_len[dat_ptr];
    assign burst_end = beat & (bus.WLAST | len_hit);
    assign bus.BRESP = (bvalid & ent_err[rsp_ptr]) ? 2'b10 : 2'b00;
`else
    assign burst_end = beat & bus.WLAST;
    assign bus.BRESP = 2'b00;
`endif

    // WRAP keeps the bits above the burst window from ADDR and wraps the low bits inside it
    always_comb begin
        base = ent_addr[dat_ptr];
        offs = ADDR_W'(beat_cnt) << ent_size[dat_ptr];
        mask = ((ADDR_W'(ent_len[dat_ptr]) + ADDR_W'(1)) << ent_size[dat_ptr]) - ADDR_W'(1);
        sum  = base + offs;
        case (ent_burst[dat_ptr])
            2'b00:   cur = base;
            2'b10:   cur = (base & ~mask) | (sum & mask);
            default: cur = sum;
        endcase
        if (!burst_active) cur = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            dat_ptr  <= '0;
            rsp_ptr  <= '0;
            occ      <= '0;
            rsp_cnt  <= '0;
            beat_cnt <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_addr[i]  <= '0;
                ent_id[i]    <= '0;
                ent_prot[i]  <= '0;
                ent_len[i]   <= '0;
                ent_size[i]  <= '0;
                ent_burst[i] <= '0;
`ifdef WLAST_CHECK_EN
                ent_err[i]   <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                ent_addr[wr_ptr]  <= bus.AWADDR;
                ent_id[wr_ptr]    <= bus.AWID;
                ent_prot[wr_ptr]  <= bus.AWPROT;
                ent_len[wr_ptr]   <= bus.AWLEN;
                ent_size[wr_ptr]  <= bus.AWSIZE;
                ent_burst[wr_ptr] <= bus.AWBURST;
`ifdef WLAST_CHECK_EN
                ent_err[wr_ptr]   <= 1'b0;
`endif
                wr_ptr <= wr_ptr + ptr_t'(1);
            end

            if (burst_end) begin
                beat_cnt <= '0;
                dat_ptr  <= dat_ptr + ptr_t'(1);
`ifdef WLAST_CHECK_EN
                if (bus.WLAST != len_hit) ent_err[dat_ptr] <= 1'b1;
`endif
            end else if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            if (b_hs) rsp_ptr <= rsp_ptr + ptr_t'(1);

            case ({push, b_hs})
                2'b10:   occ <= occ + cnt_t'(1);
                2'b01:   occ <= occ - cnt_t'(1);
                default: occ <= occ;
            endcase

            case ({burst_end, b_hs})
                2'b10:   rsp_cnt <= rsp_cnt + cnt_t'(1);
                2'b01:   rsp_cnt <= rsp_cnt - cnt_t'(1);
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_write_fifo.sv
// Scoreboard bench for axi_slave_write_fifo: expected beat addresses and B responses are queued
// by the stimulus and popped by a negedge monitor on every W beat / B handshake.
module tb_axi_slave_write_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_slave_write_fifo_if #(.ADDR_W(32), .ID_W(6)) bus ();

    axi_slave_write_fifo #(.DEPTH_LOG2(3), .ADDR_W(32), .ID_W(6)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_b[$];

`ifdef WLAST_CHECK_EN
    localparam logic [1:0] SHORT_RESP = 2'b10;
`else
    localparam logic [1:0] SHORT_RESP = 2'b00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    always @(negedge clk) begin
        if (bus.W_BEAT_EN === 1'b1) begin
            if (exp_addr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL waddr_unexpected: got %h expected none", bus.WADDR_CUR);
            end else begin
                check("waddr", bus.WADDR_CUR, exp_addr.pop_front());
            end
        end
        if (bus.BVALID === 1'b1 && bus.BREADY === 1'b1) begin
            if (exp_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected: got %h expected none", {bus.BID, bus.BRESP});
            end else begin
                check("bid_bresp", {24'd0, bus.BID, bus.BRESP}, {24'd0, exp_b.pop_front()});
            end
        end
    end

    task automatic aw(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        logic ok = 1'b0;
        bus.AWVALID = 1'b1;
        bus.AWADDR  = addr;
        bus.AWID    = id;
        bus.AWPROT  = 3'b010;
        bus.AWLEN   = len;
        bus.AWSIZE  = size;
        bus.AWBURST = burst;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.AWREADY;
        end
        if (!ok) timeout("aw_timeout");
        @(posedge clk);
        #1;
        bus.AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic last);
        logic ok = 1'b0;
        bus.WVALID = 1'b1;
        bus.WLAST  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.WREADY;
        end
        if (!ok) timeout("w_timeout");
        @(posedge clk);
        #1;
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    task automatic take_b();
        logic ok = 1'b0;
        bus.BREADY = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.BVALID;
        end
        if (!ok) timeout("b_timeout");
        @(posedge clk);
        #1;
        bus.BREADY = 1'b0;
    endtask

    initial begin
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWID = '0; bus.AWPROT = '0;
        bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", bus.AWREADY, 1);
        check("rst_wready", bus.WREADY, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_awready", bus.AWREADY, 1);
        check("idle_wready", bus.WREADY, 0);
        check("idle_bvalid", bus.BVALID, 0);
        check("idle_bid", bus.BID, 0);
        check("idle_bresp", bus.BRESP, 0);

        // INCR burst with latency checks
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h108); exp_addr.push_back(32'h10C);
        exp_b.push_back({6'd5, 2'b00});
        aw(32'h100, 6'd5, 8'd3, 3'd2, 2'b01);
        check("wready_latency", bus.WREADY, 1);
        w_beat(1'b0); w_beat(1'b0); w_beat(1'b0);
        check("bvalid_before_last", bus.BVALID, 0);
        w_beat(1'b1);
        check("bvalid_latency", bus.BVALID, 1);
        take_b();
        check("bvalid_after_hs", bus.BVALID, 0);

        // WRAP then FIXED
        exp_addr.push_back(32'h108); exp_addr.push_back(32'h10C);
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h40); exp_addr.push_back(32'h40); exp_addr.push_back(32'h40);
        exp_b.push_back({6'd7, 2'b00});
        exp_b.push_back({6'd8, 2'b00});
        aw(32'h108, 6'd7, 8'd3, 3'd2, 2'b10);
        aw(32'h40, 6'd8, 8'd2, 3'd2, 2'b00);
        w_beat(1'b0); w_beat(1'b0); w_beat(1'b0); w_beat(1'b1);
        w_beat(1'b0); w_beat(1'b0); w_beat(1'b1);
        take_b();
        take_b();

        // Fill all 8 entries, then free one
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'h200 + 32'(i) * 32'h10);
            exp_b.push_back({6'(16 + i), 2'b00});
            aw(32'h200 + 32'(i) * 32'h10, 6'(16 + i), 8'd0, 3'd2, 2'b01);
        end
        check("full_awready", bus.AWREADY, 0);
        w_beat(1'b1);
        take_b();
        check("unfull_awready", bus.AWREADY, 1);
        for (int i = 0; i < 7; i++) w_beat(1'b1);
        for (int i = 0; i < 7; i++) take_b();

        // B held while BREADY low, then in-order release
        for (int i = 1; i <= 3; i++) begin
            exp_addr.push_back(32'h100 * 32'(i + 2));
            exp_addr.push_back(32'h100 * 32'(i + 2) + 32'h4);
            exp_b.push_back({6'(i), 2'b00});
            aw(32'h100 * 32'(i + 2), 6'(i), 8'd1, 3'd2, 2'b01);
        end
        for (int i = 0; i < 3; i++) begin
            w_beat(1'b0);
            w_beat(1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bid_hold", {26'd0, bus.BID}, 1);
            check("bvalid_hold", bus.BVALID, 1);
        end
        take_b(); take_b(); take_b();

        // Early WLAST on third beat of a 4-beat burst
        exp_addr.push_back(32'h600); exp_addr.push_back(32'h604); exp_addr.push_back(32'h608);
        exp_b.push_back({6'd9, SHORT_RESP});
        aw(32'h600, 6'd9, 8'd3, 3'd2, 2'b01);
        w_beat(1'b0); w_beat(1'b0); w_beat(1'b1);
        take_b();
        check("short_idle_wready", bus.WREADY, 0);

        // Reset mid-burst with two entries queued
        exp_addr.push_back(32'h700); exp_addr.push_back(32'h704);
        aw(32'h700, 6'd10, 8'd3, 3'd2, 2'b01);
        aw(32'h800, 6'd11, 8'd0, 3'd2, 2'b01);
        w_beat(1'b0); w_beat(1'b0);
        reset = 1'b0;
        #1;
        check("midrst_awready", bus.AWREADY, 1);
        check("midrst_wready", bus.WREADY, 0);
        check("midrst_bvalid", bus.BVALID, 0);
        check("midrst_bid", bus.BID, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_wready", bus.WREADY, 0);
        exp_addr.push_back(32'h900);
        exp_b.push_back({6'd12, 2'b00});
        aw(32'h900, 6'd12, 8'd0, 3'd2, 2'b01);
        w_beat(1'b1);
        take_b();

        repeat (3) @(posedge clk);
        #1;
        check("addr_queue_drained", exp_addr.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
